// File: rtl/rxepreambl_gen_if.sv
// Byte-stream bundle between the PHY nibble assembler, the preamble stripper and the filters.
// The stimulus side (master) drives bytes; the stripper (slave) returns payload and status.
interface rxepreambl_gen_if #(
   parameter int CW = 5
);
   logic          i_en;
   logic          i_v;
   logic [7:0]    i_d;
   logic          o_v;
   logic [7:0]    o_d;
   logic          o_last;
   logic          o_err;
   logic [2:0]    o_err_code;
   logic [CW-1:0] o_pre_cnt;

   modport master (
      output i_en, i_v, i_d,
      input  o_v, o_d, o_last, o_err, o_err_code, o_pre_cnt
   );

   modport slave (
      input  i_en, i_v, i_d,
      output o_v, o_d, o_last, o_err, o_err_code, o_pre_cnt
   );
endinterface

// File: rtl/rxepreambl_gen.sv
// Receive preamble/SFD stripper: checks preamble length and SFD, forwards payload two cycles
// later through a one-byte hold register so the final byte can be tagged with o_last.
//
// state | meaning
// SYNC  | after reset; wait for an inter-frame gap before trusting i_v
// IDLE  | between frames; first valid byte selects strip or bypass
// PRE   | counting preamble bytes, waiting for the SFD
// DATA  | forwarding payload (or whole frame in bypass) through the hold register
// DROP  | rejected frame; discard bytes until the gap
module rxepreambl_gen #(
   parameter logic [7:0] PRE_BYTE = 8'h55,
   parameter logic [7:0] SFD_BYTE = 8'h5d,
   parameter int         MIN_PRE  = 7,
   parameter int         MAX_PRE  = 15,
   parameter int         CW       = 5
) (
   input  logic           i_clk,
   input  logic           i_reset_n,
   rxepreambl_gen_if.slave bus
);

   typedef enum logic [2:0] {
      S_SYNC = 3'd0,
      S_IDLE = 3'd1,
      S_PRE  = 3'd2,
      S_DATA = 3'd3,
      S_DROP = 3'd4
   } state_t;

   localparam logic [2:0]    E_BADPRE   = 3'd1;
   localparam logic [2:0]    E_SHORTPRE = 3'd2;
   localparam logic [2:0]    E_LONGPRE  = 3'd3;
   localparam logic [2:0]    E_TRUNC    = 3'd4;
   localparam logic [2:0]    E_NODATA   = 3'd5;
   localparam logic [CW-1:0] MIN_C      = CW'(MIN_PRE);
   localparam logic [CW-1:0] MAX_C      = CW'(MAX_PRE);

   state_t        state_q, state_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic [CW-1:0] cnt_inc;
   logic          en_q, en_d;
   logic          h_v_q, h_v_d;
   logic [7:0]    h_d_q, h_d_d;
   logic          o_v_q, o_v_d;
   logic [7:0]    o_d_q, o_d_d;
   logic          o_last_q, o_last_d;
   logic          o_err_q, o_err_d;
   logic [2:0]    code_q, code_d;
   logic [CW-1:0] pre_cnt_q, pre_cnt_d;

   assign cnt_inc = cnt_q + 1'b1;

   always_ff @(posedge i_clk or negedge i_reset_n) begin
      if (!i_reset_n) begin
         state_q   <= S_SYNC;
         cnt_q     <= '0;
         en_q      <= 1'b0;
         h_v_q     <= 1'b0;
         h_d_q     <= '0;
         o_v_q     <= 1'b0;
         o_d_q     <= '0;
         o_last_q  <= 1'b0;
         o_err_q   <= 1'b0;
         code_q    <= '0;
         pre_cnt_q <= '0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         en_q      <= en_d;
         h_v_q     <= h_v_d;
         h_d_q     <= h_d_d;
         o_v_q     <= o_v_d;
         o_d_q     <= o_d_d;
         o_last_q  <= o_last_d;
         o_err_q   <= o_err_d;
         code_q    <= code_d;
         pre_cnt_q <= pre_cnt_d;
      end
   end

   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      en_d      = en_q;
      h_v_d     = h_v_q;
      h_d_d     = h_d_q;
      o_v_d     = 1'b0;
      o_d_d     = 8'h00;
      o_last_d  = 1'b0;
      o_err_d   = 1'b0;
      code_d    = code_q;
      pre_cnt_d = pre_cnt_q;

      unique case (state_q)
         S_SYNC: begin
            if (!bus.i_v) state_d = S_IDLE;
         end

         S_IDLE: begin
            if (bus.i_v) begin
               en_d = bus.i_en;
               if (!bus.i_en) begin
                  state_d = S_DATA;
                  h_v_d   = 1'b1;
                  h_d_d   = bus.i_d;
               end else if (bus.i_d == PRE_BYTE) begin
                  state_d = S_PRE;
                  cnt_d   = {{(CW-1){1'b0}}, 1'b1};
               end else begin
                  state_d = S_DROP;
                  o_err_d = 1'b1;
                  code_d  = E_BADPRE;
               end
            end
         end

         S_PRE: begin
            if (!bus.i_v) begin
               state_d = S_IDLE;
               o_err_d = 1'b1;
               code_d  = E_TRUNC;
            end else if (bus.i_d == PRE_BYTE) begin
               cnt_d = cnt_inc;
               if (cnt_inc == MAX_C) begin
                  state_d = S_DROP;
                  o_err_d = 1'b1;
                  code_d  = E_LONGPRE;
               end
            end else if (bus.i_d == SFD_BYTE) begin
               pre_cnt_d = cnt_q;
               if (cnt_q >= MIN_C) begin
                  state_d = S_DATA;
                  h_v_d   = 1'b0;
               end else begin
                  state_d = S_DROP;
                  o_err_d = 1'b1;
                  code_d  = E_SHORTPRE;
               end
            end else begin
               state_d = S_DROP;
               o_err_d = 1'b1;
               code_d  = E_BADPRE;
            end
         end

         S_DATA: begin
            if (bus.i_v) begin
               if (h_v_q) begin
                  o_v_d = 1'b1;
                  o_d_d = h_d_q;
               end
               h_v_d = 1'b1;
               h_d_d = bus.i_d;
            end else begin
               state_d = S_IDLE;
               h_v_d   = 1'b0;
               if (h_v_q) begin
                  o_v_d    = 1'b1;
                  o_d_d    = h_d_q;
                  o_last_d = 1'b1;
               end else if (en_q) begin
                  // SFD immediately followed by the gap: a frame with no payload
                  o_err_d = 1'b1;
                  code_d  = E_NODATA;
               end
            end
         end

         S_DROP: begin
            if (!bus.i_v) state_d = S_IDLE;
         end

         default: state_d = S_SYNC;
      endcase
   end

   assign bus.o_v        = o_v_q;
   assign bus.o_d        = o_d_q;
   assign bus.o_last     = o_last_q;
   assign bus.o_err      = o_err_q;
   assign bus.o_err_code = code_q;
   assign bus.o_pre_cnt  = pre_cnt_q;

endmodule

// File: tb/tb_rxepreambl_gen.sv
// Directed bench for rxepreambl_gen: expected bytes/errors are queued with their due slot
// when the stimulus is planned and checked as the DUT produces them.
module tb_rxepreambl_gen;

   typedef struct {
      int         slot;
      logic [7:0] d;
      logic       last;
   } out_t;

   typedef struct {
      int         slot;
      logic [2:0] code;
   } err_t;

   logic clk = 1'b0;
   logic rst_n;
   int   checks = 0;
   int   errors = 0;
   int   tcyc   = 0;
   out_t q_out[$];
   err_t q_err[$];

   always #5 clk = ~clk;

   rxepreambl_gen_if bus ();

   rxepreambl_gen dut (
      .i_clk     (clk),
      .i_reset_n (rst_n),
      .bus       (bus)
   );

   task automatic exp_d(input int slot, input logic [7:0] d, input logic last);
      out_t e;
      e.slot = slot;
      e.d    = d;
      e.last = last;
      q_out.push_back(e);
   endtask

   task automatic exp_e(input int slot, input logic [2:0] code);
      err_t e;
      e.slot = slot;
      e.code = code;
      q_err.push_back(e);
   endtask

   task automatic check_val(input string tag, input int obs, input int exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s got=%0d exp=%0d", tag, obs, exp);
      end
   endtask

   task automatic check_outputs();
      out_t eo;
      err_t ee;
      if (bus.o_err) begin
         checks++;
         if (q_err.size() == 0) begin
            assert (bus.o_err === 1'b0) else begin
               errors++;
               $error("FAIL unexpected_err slot=%0d code=%0d exp no error", tcyc, bus.o_err_code);
            end
         end else begin
            ee = q_err.pop_front();
            assert (tcyc === ee.slot && bus.o_err_code === ee.code) else begin
               errors++;
               $error("FAIL err slot=%0d code=%0d exp slot=%0d code=%0d",
                      tcyc, bus.o_err_code, ee.slot, ee.code);
            end
         end
      end else if (q_err.size() > 0 && q_err[0].slot <= tcyc) begin
         checks++;
         ee = q_err.pop_front();
         assert (bus.o_err === 1'b1) else begin
            errors++;
            $error("FAIL missing_err slot=%0d o_err=%b exp code=%0d", tcyc, bus.o_err, ee.code);
         end
      end

      if (bus.o_v) begin
         checks++;
         if (q_out.size() == 0) begin
            assert (bus.o_v === 1'b0) else begin
               errors++;
               $error("FAIL unexpected_out slot=%0d d=%h last=%b exp no output",
                      tcyc, bus.o_d, bus.o_last);
            end
         end else begin
            eo = q_out.pop_front();
            assert (tcyc === eo.slot && bus.o_d === eo.d && bus.o_last === eo.last) else begin
               errors++;
               $error("FAIL out slot=%0d d=%h last=%b exp slot=%0d d=%h last=%b",
                      tcyc, bus.o_d, bus.o_last, eo.slot, eo.d, eo.last);
            end
         end
      end else begin
         checks++;
         assert (bus.o_d === 8'h00 && bus.o_last === 1'b0) else begin
            errors++;
            $error("FAIL idle_out slot=%0d d=%h last=%b exp d=00 last=0",
                   tcyc, bus.o_d, bus.o_last);
         end
         if (q_out.size() > 0 && q_out[0].slot <= tcyc) begin
            checks++;
            eo = q_out.pop_front();
            assert (bus.o_v === 1'b1) else begin
               errors++;
               $error("FAIL missing_out slot=%0d o_v=%b exp d=%h", tcyc, bus.o_v, eo.d);
            end
         end
      end
   endtask

   // One input slot: present the byte, let the edge sample it, then inspect the outputs
   // registered on that same edge.
   task automatic drive(input logic v, input logic [7:0] d);
      bus.i_v = v;
      bus.i_d = d;
      @(posedge clk);
      #1;
      tcyc++;
      check_outputs();
   endtask

   task automatic pre(input int n);
      for (int i = 0; i < n; i++) drive(1'b1, 8'h55);
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) drive(1'b0, 8'h00);
   endtask

   initial begin
      int s;
      logic [7:0] b;

      bus.i_en = 1'b1;
      bus.i_v  = 1'b0;
      bus.i_d  = 8'h00;
      rst_n    = 1'b0;
      #12;
      check_val("reset_outputs", int'({bus.o_v, bus.o_d, bus.o_last, bus.o_err,
                                       bus.o_err_code, bus.o_pre_cnt}), 0);
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      idle(3);

      // normal strip: 7 preamble, SFD, 4 payload bytes
      s = tcyc;
      exp_d(s + 10, 8'h01, 1'b0);
      exp_d(s + 11, 8'h02, 1'b0);
      exp_d(s + 12, 8'h03, 1'b0);
      exp_d(s + 13, 8'h04, 1'b1);
      pre(7);
      drive(1'b1, 8'h5d);
      drive(1'b1, 8'h01);
      drive(1'b1, 8'h02);
      drive(1'b1, 8'h03);
      drive(1'b1, 8'h04);
      idle(3);
      check_val("t1_pre_cnt", int'(bus.o_pre_cnt), 7);
      check_val("t1_no_err_code", int'(bus.o_err_code), 0);

      // short preamble
      s = tcyc;
      exp_e(s + 7, 3'd2);
      pre(6);
      drive(1'b1, 8'h5d);
      drive(1'b1, 8'haa);
      drive(1'b1, 8'hbb);
      idle(2);
      check_val("t2_short_pre_cnt", int'(bus.o_pre_cnt), 6);

      // long preamble: error on the 15th byte, rest dropped
      s = tcyc;
      exp_e(s + 15, 3'd3);
      pre(17);
      idle(3);
      check_val("t2_long_code_hold", int'(bus.o_err_code), 3);
      check_val("t2_long_pre_cnt", int'(bus.o_pre_cnt), 6);

      // bypass: whole frame forwarded, o_pre_cnt untouched
      bus.i_en = 1'b0;
      s = tcyc;
      exp_d(s + 2, 8'h55, 1'b0);
      exp_d(s + 3, 8'h5d, 1'b0);
      exp_d(s + 4, 8'h11, 1'b1);
      drive(1'b1, 8'h55);
      drive(1'b1, 8'h5d);
      drive(1'b1, 8'h11);
      idle(2);
      check_val("t4_bypass_pre_cnt", int'(bus.o_pre_cnt), 6);

      // bypass frame with i_en raised mid-frame
      s = tcyc;
      exp_d(s + 2, 8'h55, 1'b0);
      exp_d(s + 3, 8'h5d, 1'b0);
      exp_d(s + 4, 8'h22, 1'b0);
      exp_d(s + 5, 8'h33, 1'b1);
      drive(1'b1, 8'h55);
      drive(1'b1, 8'h5d);
      bus.i_en = 1'b1;
      drive(1'b1, 8'h22);
      drive(1'b1, 8'h33);
      idle(2);

      // strip frame with i_en dropped mid-preamble
      s = tcyc;
      exp_d(s + 10, 8'h44, 1'b1);
      pre(3);
      bus.i_en = 1'b0;
      pre(4);
      drive(1'b1, 8'h5d);
      drive(1'b1, 8'h44);
      bus.i_en = 1'b1;
      idle(2);
      check_val("t4_toggle_pre_cnt", int'(bus.o_pre_cnt), 7);

      // back-to-back bypass frames with a single-cycle gap
      bus.i_en = 1'b0;
      s = tcyc;
      exp_d(s + 2, 8'ha1, 1'b0);
      exp_d(s + 3, 8'ha2, 1'b1);
      exp_d(s + 5, 8'hb1, 1'b1);
      drive(1'b1, 8'ha1);
      drive(1'b1, 8'ha2);
      drive(1'b0, 8'h00);
      drive(1'b1, 8'hb1);
      bus.i_en = 1'b1;
      idle(2);

      // bad preamble mid-preamble and on the very first byte
      s = tcyc;
      exp_e(s + 3, 3'd1);
      drive(1'b1, 8'h55);
      drive(1'b1, 8'h55);
      drive(1'b1, 8'ha5);
      drive(1'b1, 8'h55);
      drive(1'b1, 8'h11);
      idle(2);
      s = tcyc;
      exp_e(s + 1, 3'd1);
      drive(1'b1, 8'ha5);
      drive(1'b1, 8'h55);
      idle(2);
      check_val("t3_badpre_code_hold", int'(bus.o_err_code), 1);

      // truncated preamble
      s = tcyc;
      exp_e(s + 4, 3'd4);
      pre(3);
      idle(2);

      // SFD then gap: no payload
      s = tcyc;
      exp_e(s + 9, 3'd5);
      pre(7);
      drive(1'b1, 8'h5d);
      idle(2);
      check_val("t3_nodata_pre_cnt", int'(bus.o_pre_cnt), 7);

      // minimum frames separated by single-cycle gaps
      s = tcyc;
      for (int f = 0; f < 3; f++) exp_d(s + 10 * f + 10, 8'hc0 + 8'(f), 1'b1);
      for (int f = 0; f < 3; f++) begin
         b = 8'hc0 + 8'(f);
         pre(7);
         drive(1'b1, 8'h5d);
         drive(1'b1, b);
         drive(1'b0, 8'h00);
      end
      idle(2);

      // asynchronous reset mid-payload, released while the frame is still running
      s = tcyc;
      exp_d(s + 10, 8'h01, 1'b0);
      exp_d(s + 11, 8'h02, 1'b0);
      exp_d(s + 12, 8'h03, 1'b0);
      pre(7);
      drive(1'b1, 8'h5d);
      drive(1'b1, 8'h01);
      drive(1'b1, 8'h02);
      drive(1'b1, 8'h03);
      drive(1'b1, 8'h04);
      bus.i_d = 8'h05;
      rst_n   = 1'b0;
      #1;
      check_val("t6_reset_outputs", int'({bus.o_v, bus.o_d, bus.o_last, bus.o_err,
                                          bus.o_err_code, bus.o_pre_cnt}), 0);
      drive(1'b1, 8'h05);
      drive(1'b1, 8'h06);
      rst_n = 1'b1;
      drive(1'b1, 8'h07);
      drive(1'b1, 8'h08);
      drive(1'b1, 8'h09);
      drive(1'b0, 8'h00);
      s = tcyc;
      exp_d(s + 10, 8'h9a, 1'b1);
      pre(7);
      drive(1'b1, 8'h5d);
      drive(1'b1, 8'h9a);
      idle(3);
      check_val("t6_after_reset_pre_cnt", int'(bus.o_pre_cnt), 7);
      check_val("t6_after_reset_code", int'(bus.o_err_code), 0);

      check_val("out_queue_drained", q_out.size(), 0);
      check_val("err_queue_drained", q_err.size(), 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
